// File: rtl/fold_mul_frontend.sv
// rtl/fold_mul_frontend.sv - issue/collect front end for the folding Karatsuba multiplier
// Credits (inflight + FIFO occupancy) bound outstanding work so the no-backpressure multiplier never overruns the FIFO.
module fold_mul_frontend #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  input  logic [127:0]   s_x_i,
  output logic [127:0]   m_x_o,
  output logic [64:0]    m_x1x0_o,
  output logic           m_in_valid_o,
  input  logic [383:0]   m_p_i,
  input  logic           m_out_valid_i,
  output logic           r_valid_o,
  input  logic           r_ready_i,
  output logic [383:0]   r_p_o,
  output logic [CW-1:0]  inflight_o,
  output logic           err_o
);

  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           err_q, err_d;
  logic [127:0]   m_x_q, m_x_d;
  logic [64:0]    m_x1x0_q, m_x1x0_d;
  logic           m_in_valid_q, m_in_valid_d;
  logic [383:0]   mem_q [DEPTH];

  logic           accept, retire, full, push, pop;
  logic [64:0]    half_sum;

  assign s_ready_o = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign accept    = s_valid_i && s_ready_o;
  // A product with no operand outstanding is spurious and must not disturb the counters.
  assign retire    = m_out_valid_i && (inflight_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign push      = retire && !full;
  assign pop       = r_valid_o && r_ready_i;
  assign half_sum  = {1'b0, s_x_i[127:64]} + {1'b0, s_x_i[63:0]};

  always_comb begin
    m_x_d        = m_x_q;
    m_x1x0_d     = m_x1x0_q;
    m_in_valid_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    if (accept) begin
      m_x_d        = s_x_i;
      m_x1x0_d     = half_sum;
      m_in_valid_d = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (m_out_valid_i && !push) err_d = 1'b1;
    inflight_d = inflight_q + CW'(accept) - CW'(retire);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      m_x_q        <= '0;
      m_x1x0_q     <= '0;
      m_in_valid_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      m_x_q        <= m_x_d;
      m_x1x0_q     <= m_x1x0_d;
      m_in_valid_q <= m_in_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= m_p_i;
  end

  assign m_x_o        = m_x_q;
  assign m_x1x0_o     = m_x1x0_q;
  assign m_in_valid_o = m_in_valid_q;
  assign r_valid_o    = (count_q != '0);
  assign r_p_o        = mem_q[rd_ptr_q];
  assign inflight_o   = inflight_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fold_mul_frontend.sv
// tb/tb_fold_mul_frontend.sv - scoreboard bench for fold_mul_frontend
// Multiplier stand-in returns {256'h0, X} with the 11-stage in_valid-to-out_valid delay of the real core.
module tb_fold_mul_frontend;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LAT   = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid, s_ready;
  logic [127:0]   s_x;
  logic [127:0]   m_x;
  logic [64:0]    m_x1x0;
  logic           m_in_valid;
  logic [383:0]   m_p;
  logic           m_out_valid;
  logic           r_valid, r_ready;
  logic [383:0]   r_p;
  logic [CW-1:0]  inflight;
  logic           err;

  logic           inj_v;
  logic [383:0]   inj_p;
  logic           pv [LAT];
  logic [127:0]   pd [LAT];

  int vectors = 0;
  int fails   = 0;
  int acc_cnt = 0;
  logic [383:0] sb [$];

  fold_mul_frontend #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_x_i(s_x),
    .m_x_o(m_x), .m_x1x0_o(m_x1x0), .m_in_valid_o(m_in_valid),
    .m_p_i(m_p), .m_out_valid_i(m_out_valid),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_p_o(r_p),
    .inflight_o(inflight), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= m_in_valid;
      pd[0] <= m_x;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign m_out_valid = pv[LAT-1] | inj_v;
  assign m_p         = inj_v ? inj_p : {256'h0, pd[LAT-1]};

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) begin
        sb.push_back({256'h0, s_x});
        acc_cnt++;
      end
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL pop_unexpected: got %h expected no product", r_p);
        end else begin
          chk("r_p_order", r_p, sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] x, output int stalls);
    s_valid = 1'b1;
    s_x     = x;
    stalls  = 0;
    while (!s_ready && stalls < 200) begin
      step();
      stalls++;
    end
    step();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((sb.size() != 0 || inflight != 0 || r_valid) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", n < bound, 1);
  endtask

  initial begin
    int st, tot, a0, n, max_inf;
    logic [CW-1:0] inf0;
    s_valid = 1'b0; s_x = '0; r_ready = 1'b0; inj_v = 1'b0; inj_p = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_in_valid", m_in_valid, 0);
    chk("rst_m_x", m_x, 0);
    chk("rst_m_x1x0", m_x1x0, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // single all-ones operand
    issue({128{1'b1}}, st);
    s_valid = 1'b0;
    chk("single_m_in_valid_hi", m_in_valid, 1);
    chk("single_m_x", m_x, {128{1'b1}});
    chk("single_m_x1x0", m_x1x0, 65'h1_FFFF_FFFF_FFFF_FFFE);
    step();
    chk("single_m_in_valid_lo", m_in_valid, 0);
    n = 1;
    while (!r_valid && n < 40) begin
      step();
      n++;
    end
    chk("single_latency", n, 12);
    r_ready = 1'b1;
    wait_idle(20);

    issue({64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003}, st);
    s_valid = 1'b0;
    chk("carry_m_x1x0", m_x1x0, 65'h1_0000_0000_0000_0004);
    wait_idle(30);

    // back-to-back 1..20
    tot = 0;
    a0  = acc_cnt;
    for (int i = 1; i <= 20; i++) begin
      issue(128'(i), st);
      tot += st;
    end
    s_valid = 1'b0;
    chk("b2b_stalls", tot, 0);
    chk("b2b_accepts", acc_cnt - a0, 20);
    wait_idle(40);
    chk("b2b_err", err, 0);

    // credit exhaustion
    r_ready = 1'b0;
    a0 = acc_cnt;
    max_inf = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_x = 128'(200 + i);
      step();
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
    end
    chk("credit_accepts", acc_cnt - a0, 16);
    chk("credit_s_ready_lo", s_ready, 0);
    chk("credit_inflight_peak", max_inf, 12);
    chk("credit_inflight_drained", inflight, 0);
    chk("credit_r_valid", r_valid, 1);
    a0 = acc_cnt;
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    repeat (30) step();
    chk("credit_one_more", acc_cnt - a0, 1);
    chk("credit_s_ready_relo", s_ready, 0);
    s_valid = 1'b0;
    r_ready = 1'b1;
    wait_idle(60);

    // accept, capture and pop on the same edge across pointer wrap
    tot = 0;
    inf0 = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 25) begin
        s_valid = 1'b1;
        chk("simul_events", s_ready && m_out_valid && r_valid && r_ready, 1);
        inf0 = inflight;
      end
      issue(128'(1000 + i), st);
      tot += st;
      if (i == 25) begin
        chk("simul_inflight", inflight, inf0);
        chk("simul_r_valid", r_valid, 1);
      end
    end
    s_valid = 1'b0;
    chk("simul_stalls", tot, 0);
    wait_idle(60);
    chk("pre_spurious_err", err, 0);

    // spurious product
    inj_p = 384'hDEAD_BEEF;
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_r_valid", r_valid, 0);
    chk("spur_inflight", inflight, 0);
    repeat (5) step();
    chk("spur_err_sticky", err, 1);

    // reset with 3 queued and 5 in flight
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(128'(5000 + i), st);
    s_valid = 1'b0;
    repeat (14) step();
    for (int i = 0; i < 5; i++) issue(128'(6000 + i), st);
    s_valid = 1'b0;
    chk("pre_reset_inflight", inflight, 5);
    chk("pre_reset_r_valid", r_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_r_valid", r_valid, 0);
    chk("async_m_in_valid", m_in_valid, 0);
    chk("async_inflight", inflight, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_s_ready", s_ready, 1);
    chk("post_reset_err", err, 0);
    repeat (20) step();
    chk("post_reset_no_stale", r_valid, 0);
    r_ready = 1'b1;
    issue(128'h1234_5678, st);
    s_valid = 1'b0;
    wait_idle(40);
    chk("final_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
